// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: pops 64-bit SPI commands from an AXI-Stream, launches them on the
// SPI master, waits for completion, returns the low read word on an output stream for
// read commands, enforces an idle gap between transfers and flags a master that never
// goes busy.
module spi_cmd_sequencer #(
  parameter int NUM_OF_CS    = 1,
  parameter int GAP_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [15:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 spi_start_o,
  output logic [15:0]          dat_wr_h_o,
  output logic [15:0]          dat_wr_l_o,
  output logic                 cfg_rw_o,
  output logic [NUM_OF_CS-1:0] cfg_cs_act_o,
  output logic [4:0]           cfg_h_lng_o,
  output logic [4:0]           cfg_l_lng_o,
  input  logic                 spi_busy_i,
  input  logic [15:0]          dat_rd_l_i,
  output logic                 sts_idle_o,
  output logic                 sts_timeout_o,
  input  logic                 sts_clr_i,
  output logic [15:0]          cmd_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_CAPTURE, S_PUSH, S_GAP
  } state_t;

  localparam logic [7:0] TMO_LOAD = 8'(BUSY_TIMEOUT);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_t                state_q, state_d;
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  armed_q;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [15:0]           m_tdata_q;
  logic                  timeout_q, timeout_d;
  logic [15:0]           cmd_cnt_q, cmd_cnt_d;
  logic [15:0]           dat_h_q, dat_l_q;
  logic                  rw_q;
  logic [NUM_OF_CS-1:0]  cs_q;
  logic [4:0]            h_lng_q, l_lng_q;
  logic                  accept, capture, inc_cnt, set_tmo;
  logic                  unused_bits;

  // Upper command bits and unused chip-select bits are intentionally ignored.
  assign unused_bits = ^s_axis_tdata[63:43];

  // armed_q keeps tready low while reset is asserted and for the first cycle after it.
  assign s_axis_tready = armed_q && (state_q == S_IDLE) && !m_tvalid_q;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign spi_start_o   = (state_q == S_START);
  assign sts_idle_o    = (state_q == S_IDLE) && !s_axis_tvalid;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign sts_timeout_o = timeout_q;
  assign cmd_cnt_o     = cmd_cnt_q;
  assign dat_wr_h_o    = dat_h_q;
  assign dat_wr_l_o    = dat_l_q;
  assign cfg_rw_o      = rw_q;
  assign cfg_cs_act_o  = cs_q;
  assign cfg_h_lng_o   = h_lng_q;
  assign cfg_l_lng_o   = l_lng_q;

  // Next-state logic for the command sequencer, timers and status.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    m_tvalid_d = m_tvalid_q && !m_axis_tready;
    capture    = 1'b0;
    inc_cnt    = 1'b0;
    set_tmo    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        tmo_cnt_d = TMO_LOAD;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_busy_i) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 8'd1;
          if (tmo_cnt_q <= 8'd1) begin
            set_tmo   = 1'b1;
            gap_cnt_d = GAP_LOAD;
            state_d   = S_GAP;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy_i) begin
          if (rw_q) begin
            state_d = S_CAPTURE;
          end else begin
            inc_cnt   = 1'b1;
            gap_cnt_d = GAP_LOAD;
            state_d   = S_GAP;
          end
        end
      end
      S_CAPTURE: begin
        capture    = 1'b1;
        inc_cnt    = 1'b1;
        m_tvalid_d = 1'b1;
        state_d    = S_PUSH;
      end
      S_PUSH: begin
        gap_cnt_d = GAP_LOAD;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = S_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // A clear request wins over a same-cycle increment or timeout.
    if (sts_clr_i) begin
      cmd_cnt_d = 16'd0;
      timeout_d = 1'b0;
    end else begin
      cmd_cnt_d = cmd_cnt_q + (inc_cnt ? 16'd1 : 16'd0);
      timeout_d = timeout_q || set_tmo;
    end
  end

  // Control state, timers, stream valid and status registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= 8'd0;
      gap_cnt_q  <= 8'd0;
      armed_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      timeout_q  <= 1'b0;
      cmd_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      armed_q    <= 1'b1;
      m_tvalid_q <= m_tvalid_d;
      timeout_q  <= timeout_d;
      cmd_cnt_q  <= cmd_cnt_d;
    end
  end

  // Command fields latched on accept and held until the next accepted command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dat_l_q <= 16'd0;
      dat_h_q <= 16'd0;
      l_lng_q <= 5'd0;
      h_lng_q <= 5'd0;
      rw_q    <= 1'b0;
      cs_q    <= '0;
    end else if (accept) begin
      dat_l_q <= s_axis_tdata[15:0];
      dat_h_q <= s_axis_tdata[31:16];
      l_lng_q <= s_axis_tdata[36:32];
      h_lng_q <= s_axis_tdata[41:37];
      rw_q    <= s_axis_tdata[42];
      cs_q    <= s_axis_tdata[43 +: NUM_OF_CS];
    end
  end

  // Read word sampled in CAPTURE, once the master's output has settled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     m_tdata_q <= 16'd0;
    else if (capture) m_tdata_q <= dat_rd_l_i;
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: table of commands run against a behavioural SPI
// master, scoreboard for read words, plus sequences for hold, back-to-back, reset and wrap.
module tb_spi_cmd_sequencer;
  localparam int NCS = 1;
  localparam int GAP = 4;
  localparam int TMO = 15;

  logic              aclk;
  logic              aresetn;
  logic [63:0]       s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [15:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              spi_start_o;
  logic [15:0]       dat_wr_h_o, dat_wr_l_o;
  logic              cfg_rw_o;
  logic [NCS-1:0]    cfg_cs_act_o;
  logic [4:0]        cfg_h_lng_o, cfg_l_lng_o;
  logic              spi_busy_i;
  logic [15:0]       dat_rd_l_i;
  logic              sts_idle_o, sts_timeout_o, sts_clr_i;
  logic [15:0]       cmd_cnt_o;

  spi_cmd_sequencer #(.NUM_OF_CS(NCS), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .spi_start_o(spi_start_o), .dat_wr_h_o(dat_wr_h_o), .dat_wr_l_o(dat_wr_l_o),
    .cfg_rw_o(cfg_rw_o), .cfg_cs_act_o(cfg_cs_act_o), .cfg_h_lng_o(cfg_h_lng_o),
    .cfg_l_lng_o(cfg_l_lng_o), .spi_busy_i(spi_busy_i), .dat_rd_l_i(dat_rd_l_i),
    .sts_idle_o(sts_idle_o), .sts_timeout_o(sts_timeout_o), .sts_clr_i(sts_clr_i),
    .cmd_cnt_o(cmd_cnt_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] h;
    logic [15:0] l;
    logic [4:0]  hl;
    logic [4:0]  ll;
    logic        rw;
    logic [7:0]  cs;
    int          busy;   // busy-high cycles of the master model, 0 = never busy
    logic [15:0] rd;
    logic        to;     // expected timeout
  } vec_t;

  vec_t        vt[7];
  logic [15:0] sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mdl_busy_len = 0;
  logic [15:0] mdl_rd = 16'h0;
  int          last_fall_cyc = 0;
  bit          have_fall = 0;
  int          last_start_cyc = 0;
  int          to_rise_cyc = 0;
  int          start_cnt = 0;
  int          exp_cnt = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] h, input logic [15:0] l, input logic [4:0] hl,
                                     input logic [4:0] ll, input logic rw, input logic [7:0] cs);
    return {13'h1ABC, cs, rw, hl, ll, h, l};
  endfunction

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Behavioural SPI master: busy for mdl_busy_len cycles after a start pulse.
  initial begin
    spi_busy_i = 1'b0;
    dat_rd_l_i = 16'h0;
    forever begin
      @(negedge aclk);
      if (aresetn && spi_start_o && mdl_busy_len > 0) begin
        int          len;
        logic [15:0] rd;
        len = mdl_busy_len;
        rd  = mdl_rd;
        dat_rd_l_i = 16'h0;
        @(negedge aclk);
        spi_busy_i = 1'b1;
        repeat (len) @(negedge aclk);
        dat_rd_l_i    = rd;
        spi_busy_i    = 1'b0;
        last_fall_cyc = cyc;
        have_fall     = 1'b1;
      end
    end
  end

  // Monitors: start pulse width/spacing, timeout rise time, read-word scoreboard.
  initial begin
    bit prev_start;
    bit prev_to;
    prev_start = 1'b0;
    prev_to    = 1'b0;
    forever begin
      @(negedge aclk);
      if (spi_start_o) begin
        start_cnt++;
        chk("start_width", 64'(prev_start), 64'd0);
        if (have_fall) chk("gap_spacing", 64'((cyc - last_fall_cyc) > GAP), 64'd1);
        last_start_cyc = cyc;
      end
      if (sts_timeout_o && !prev_to) to_rise_cyc = cyc;
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got beat %0h expected no beat", m_axis_tdata);
        end else begin
          chk("rd_data", 64'(m_axis_tdata), 64'(sb_q.pop_front()));
        end
      end
      prev_start = spi_start_o;
      prev_to    = sts_timeout_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [63:0] d, input bit keep);
    int t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && t < 400) begin
      @(negedge aclk);
      t++;
    end
    if (!s_axis_tready) begin
      chk("accept", 64'(s_axis_tready), 64'd1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    if (!keep) s_axis_tvalid = 1'b0;
    @(negedge aclk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!s_axis_tready && t < 400) begin
      @(negedge aclk);
      t++;
    end
    if (!s_axis_tready) chk("wait_idle", 64'(s_axis_tready), 64'd1);
  endtask

  task automatic clr_status();
    sts_clr_i = 1'b1;
    @(negedge aclk);
    sts_clr_i = 1'b0;
    @(negedge aclk);
    exp_cnt = 0;
  endtask

  initial begin
    int t;
    vt[0] = '{16'h00AB, 16'h1234, 5'd8,  5'd16, 1'b0, 8'h01, 40, 16'h0000, 1'b0};
    vt[1] = '{16'h0000, 16'h0000, 5'd0,  5'd16, 1'b1, 8'h01, 10, 16'hBEEF, 1'b0};
    vt[2] = '{16'hFFFF, 16'h8001, 5'd0,  5'd0,  1'b0, 8'h01, 1,  16'h0000, 1'b0};
    vt[3] = '{16'h1357, 16'h2468, 5'd31, 5'd31, 1'b1, 8'hFF, 3,  16'h0001, 1'b0};
    vt[4] = '{16'hA5A5, 16'h5A5A, 5'd4,  5'd4,  1'b0, 8'h01, 0,  16'h0000, 1'b1};
    vt[5] = '{16'h0F0F, 16'hF0F0, 5'd1,  5'd2,  1'b1, 8'hFE, 5,  16'hFFFF, 1'b0};
    vt[6] = '{16'h0001, 16'h0002, 5'd3,  5'd3,  1'b1, 8'h02, 0,  16'h0000, 1'b1};

    aresetn = 1'b0; s_axis_tdata = 64'h0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1; sts_clr_i = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_ctrl", 64'({spi_start_o, s_axis_tready, m_axis_tvalid, cfg_rw_o, cfg_cs_act_o,
                         cfg_h_lng_o, cfg_l_lng_o, sts_timeout_o}), 64'd0);
    chk("rst_data", {m_axis_tdata, dat_wr_h_o, dat_wr_l_o, cmd_cnt_o}, 64'd0);
    chk("rst_idle", 64'(sts_idle_o), 64'd1);
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);

    // Table-driven commands.
    for (int i = 0; i < 7; i++) begin
      mdl_busy_len = vt[i].busy;
      mdl_rd       = vt[i].rd;
      if (vt[i].rw && !vt[i].to) sb_q.push_back(vt[i].rd);
      send(mk(vt[i].h, vt[i].l, vt[i].hl, vt[i].ll, vt[i].rw, vt[i].cs), 1'b0);
      chk("cfg_load", 64'({dat_wr_h_o, dat_wr_l_o, cfg_h_lng_o, cfg_l_lng_o, cfg_rw_o, cfg_cs_act_o}),
          64'({vt[i].h, vt[i].l, vt[i].hl, vt[i].ll, vt[i].rw, vt[i].cs[NCS-1:0]}));
      wait_idle();
      if (!vt[i].to) exp_cnt++;
      chk("cfg_hold", 64'({dat_wr_h_o, dat_wr_l_o, cfg_h_lng_o, cfg_l_lng_o, cfg_rw_o, cfg_cs_act_o}),
          64'({vt[i].h, vt[i].l, vt[i].hl, vt[i].ll, vt[i].rw, vt[i].cs[NCS-1:0]}));
      chk("cmd_cnt", 64'(cmd_cnt_o), 64'(exp_cnt));
      chk("timeout_flag", 64'(sts_timeout_o), 64'(vt[i].to));
      if (vt[i].to) begin
        chk("timeout_latency", 64'(to_rise_cyc - last_start_cyc), 64'(TMO + 1));
        clr_status();
        chk("clr_timeout", 64'(sts_timeout_o), 64'd0);
        chk("clr_cnt", 64'(cmd_cnt_o), 64'd0);
      end
    end

    // Read word held with tready low; pending command must wait.
    @(posedge aclk); #1; m_axis_tready = 1'b0;
    @(negedge aclk);
    mdl_busy_len = 10; mdl_rd = 16'hBEEF;
    sb_q.push_back(16'hBEEF);
    send(mk(16'h0000, 16'h0000, 5'd8, 5'd8, 1'b1, 8'h01), 1'b0);
    t = 0;
    while (!m_axis_tvalid && t < 200) begin
      @(negedge aclk);
      t++;
    end
    chk("hold_seen", 64'(m_axis_tvalid), 64'd1);
    s_axis_tdata = mk(16'h1111, 16'h2222, 5'd8, 5'd8, 1'b0, 8'h01);
    s_axis_tvalid = 1'b1;
    mdl_busy_len = 6;
    for (int k = 0; k < 20; k++) begin
      chk("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("hold_tdata", 64'(m_axis_tdata), 64'hBEEF);
      chk("hold_s_tready", 64'(s_axis_tready), 64'd0);
      @(negedge aclk);
    end
    chk("idle_pending", 64'(sts_idle_o), 64'd0);
    exp_cnt++;
    chk("hold_cnt", 64'(cmd_cnt_o), 64'(exp_cnt));
    @(posedge aclk); #1; m_axis_tready = 1'b1;
    send(mk(16'h1111, 16'h2222, 5'd8, 5'd8, 1'b0, 8'h01), 1'b0);
    chk("after_hold_cfg", 64'({dat_wr_h_o, dat_wr_l_o}), 64'h11112222);
    wait_idle();
    exp_cnt++;
    chk("after_hold_cnt", 64'(cmd_cnt_o), 64'(exp_cnt));

    // Back-to-back commands with tvalid held high.
    clr_status();
    mdl_busy_len = 5;
    t = start_cnt;
    send(mk(16'h0001, 16'h0001, 5'd2, 5'd2, 1'b0, 8'h01), 1'b1);
    send(mk(16'h0002, 16'h0002, 5'd2, 5'd2, 1'b0, 8'h01), 1'b1);
    send(mk(16'h0003, 16'h0003, 5'd2, 5'd2, 1'b0, 8'h01), 1'b0);
    wait_idle();
    chk("b2b_starts", 64'(start_cnt - t), 64'd3);
    chk("b2b_cnt", 64'(cmd_cnt_o), 64'd3);

    // Reset in the middle of a transfer.
    mdl_busy_len = 40;
    send(mk(16'hDEAD, 16'hBEEF, 5'd8, 5'd8, 1'b0, 8'h01), 1'b0);
    repeat (10) @(negedge aclk);
    chk("mid_busy", 64'(spi_busy_i), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({spi_start_o, s_axis_tready, m_axis_tvalid, cfg_rw_o, cfg_cs_act_o,
                             cfg_h_lng_o, cfg_l_lng_o, sts_timeout_o}), 64'd0);
    chk("mid_rst_data", {m_axis_tdata, dat_wr_h_o, dat_wr_l_o, cmd_cnt_o}, 64'd0);
    chk("mid_rst_idle", 64'(sts_idle_o), 64'd1);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_cnt = 0;
    t = 0;
    while (spi_busy_i && t < 100) begin
      @(negedge aclk);
      t++;
    end
    repeat (GAP + 3) @(negedge aclk);
    mdl_busy_len = 4; mdl_rd = 16'h5A5A;
    sb_q.push_back(16'h5A5A);
    send(mk(16'h0000, 16'h0000, 5'd4, 5'd4, 1'b1, 8'h01), 1'b0);
    wait_idle();
    chk("post_rst_cnt", 64'(cmd_cnt_o), 64'd1);

    // Counter wrap.
    @(negedge aclk);
    force dut.cmd_cnt_q = 16'hFFFF;
    @(negedge aclk);
    release dut.cmd_cnt_q;
    @(negedge aclk);
    chk("wrap_preload", 64'(cmd_cnt_o), 64'hFFFF);
    mdl_busy_len = 2;
    send(mk(16'h0000, 16'h0000, 5'd0, 5'd0, 1'b0, 8'h01), 1'b0);
    wait_idle();
    chk("wrap_cnt", 64'(cmd_cnt_o), 64'h0000);

    repeat (5) @(negedge aclk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
